cafe_dispense_sequencer: RTL and testbench
==========================================

Name: cafe_dispense_sequencer

Overview:
Sequences one drink cycle of the coffee/tea machine: accepts coins, takes a selection, checks resources, then runs timed heat and pour phases and returns change.
- Accumulates coin credit from the 10-unit (md) and 5-unit (mc) coin pulses.
- Drives heater, pump and the cafe/te valves; arbitrates a single selection at a time.
- Issues change or a full refund.
- Sits between the front-panel/coin inputs and the actuator drivers.

Parameters:
PRICE_CAFE, 15, credit units charged for coffee
PRICE_TE, 10, credit units charged for tea
CREDIT_W, 6, width of credit/change values
MAX_CREDIT, 40, credit ceiling; coins that would exceed it are rejected
HEAT_CYC, 8, clock cycles in HEAT phase (>=1)
POUR_CYC, 12, clock cycles in POUR phase (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
md  in  1  10-unit coin accepted, single-cycle pulse
mc  in  1  5-unit coin accepted, single-cycle pulse
bc  in  1  coffee button, single-cycle pulse
bt  in  1  tea button, single-cycle pulse
ha  in  1  water present (level)
hc  in  1  coffee powder present (level)
heater_on  out  1  heater enable
pump_on  out  1  water pump enable
valve_cafe  out  1  coffee valve open
valve_te  out  1  tea valve open
busy  out  1  high in any state other than IDLE
credit  out  CREDIT_W  current accumulated credit
coin_reject  out  1  one-cycle pulse: coin not accepted, returned mechanically
change_req  out  1  one-cycle pulse: dispense change_val
change_val  out  CREDIT_W  amount to return, valid while change_req=1
err  out  1  one-cycle pulse with change_req on refund (missing resource or abort)

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs 0. credit=0, phase counter=0, selection register cleared. Reset mid-dispense drops all actuators in the same instant and discards credit.
- All outputs are registered. Actuator outputs are a function of state and the latched selection.

State machine: IDLE, HEAT, POUR, CHANGE, REFUND.

IDLE coin handling:
- Coin value = 10*md + 5*mc; md and mc together add 15.
- If credit + value <= MAX_CREDIT, credit updates next cycle.
- Otherwise credit is unchanged and coin_reject pulses next cycle.
- Coins arriving in any non-IDLE state: coin_reject, credit unchanged.

IDLE selection:
- bc and bt in the same cycle: both ignored.
- A selection with credit < price is ignored; no state change, no err.
- Coin and selection in the same cycle: the coin is applied first, and the selection is evaluated against the updated credit.
- Valid selection, resources present (cafe needs ha&hc; te needs ha): latch selection, counter=0, go to HEAT.
- Valid selection, resource missing: go to REFUND.

HEAT:
- heater_on=1 for exactly HEAT_CYC cycles, then go to POUR with counter reset.
- Buttons are ignored in HEAT.

POUR:
- pump_on=1, and valve_cafe or valve_te =1 per the latched selection, for exactly POUR_CYC cycles.
- On the last cycle, credit <= credit - price.
- If the resulting credit > 0, go to CHANGE; else go to IDLE.
- Buttons are ignored in POUR.

Abort:
- ha falling to 0 in HEAT or POUR: go to REFUND next cycle, actuators off.
- Credit has not yet been deducted, so the full credit is refunded.
- hc loss after HEAT has started is ignored.

CHANGE (1 cycle): change_req=1, change_val=credit, credit<=0, go to IDLE.

REFUND (1 cycle): change_req=1, err=1, change_val=credit, credit<=0, go to IDLE.

Arithmetic:
- Credit is unsigned CREDIT_W bits.
- MAX_CREDIT+15 must fit in CREDIT_W; this is an elaboration check.
- No wrap-around is possible by construction.

Latency:
- Selection pulse to heater_on: 1 cycle.
- Coffee from selection to change_req: 1+HEAT_CYC+POUR_CYC cycles.

Test Plan:
- Exact-price coffee: md then mc, ha=hc=1, bc -> credit 10 then 15; heater_on 8 cycles; pump_on+valve_cafe 12 cycles; credit 0; no change_req; back to IDLE.
- Overpay tea: md, md (credit 20), ha=1, bt -> heat/pour with valve_te; then change_req=1 for 1 cycle with change_val=10, err=0; credit 0.
- Missing coffee powder: md+mc same cycle (credit 15), ha=1, hc=0, bc -> next cycle REFUND: change_req=1, err=1, change_val=15; no actuator ever on.
- Credit ceiling and busy coins: four md (credit 40), fifth md -> coin_reject pulse, credit stays 40. An mc during POUR -> coin_reject, credit unchanged.
- Abort and guards: ha drops at POUR cycle 5 -> all actuators 0 next cycle, REFUND with change_val=full credit, err=1. bc&bt same cycle, or bc with credit 10 -> ignored, stays IDLE.
- Async reset mid-HEAT: assert rst between clock edges -> heater_on, busy, credit go 0 immediately; after release, IDLE with a coin accepted normally.

Source files
------------

// File: rtl/cafe_dispense_sequencer.sv
// Coffee/tea dispense sequencer: coin credit, selection arbitration,
// timed heat/pour phases, change and refund.
module cafe_dispense_sequencer #(
    parameter int PRICE_CAFE = 15,
    parameter int PRICE_TE   = 10,
    parameter int CREDIT_W   = 6,
    parameter int MAX_CREDIT = 40,
    parameter int HEAT_CYC   = 8,
    parameter int POUR_CYC   = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                md,
    input  logic                mc,
    input  logic                bc,
    input  logic                bt,
    input  logic                ha,
    input  logic                hc,
    output logic                heater_on,
    output logic                pump_on,
    output logic                valve_cafe,
    output logic                valve_te,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                change_req,
    output logic [CREDIT_W-1:0] change_val,
    output logic                err
);

    localparam int CNT_MAX = (HEAT_CYC > POUR_CYC) ? HEAT_CYC : POUR_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CREDIT_W-1:0] P_CAFE  = CREDIT_W'(PRICE_CAFE);
    localparam logic [CREDIT_W-1:0] P_TE    = CREDIT_W'(PRICE_TE);
    localparam logic [CREDIT_W-1:0] COIN_MD = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] COIN_MC = CREDIT_W'(5);
    localparam logic [CREDIT_W:0]   CR_MAX  = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CNT_W-1:0]    HEAT_LAST = CNT_W'(HEAT_CYC - 1);
    localparam logic [CNT_W-1:0]    POUR_LAST = CNT_W'(POUR_CYC - 1);

    generate
        if (MAX_CREDIT + 15 >= (1 << CREDIT_W)) begin : g_bad_credit_w
            $error("CREDIT_W too narrow for MAX_CREDIT+15");
        end
        if (HEAT_CYC < 1 || POUR_CYC < 1) begin : g_bad_phase
            $error("HEAT_CYC and POUR_CYC must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        HEAT,
        POUR,
        CHANGE,
        REFUND
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                sel_cafe_q, sel_cafe_d;
    logic                heater_on_q, heater_on_d;
    logic                pump_on_q, pump_on_d;
    logic                valve_cafe_q, valve_cafe_d;
    logic                valve_te_q, valve_te_d;
    logic                busy_q, busy_d;
    logic                coin_reject_q, coin_reject_d;
    logic                change_req_q, change_req_d;
    logic [CREDIT_W-1:0] change_val_q, change_val_d;
    logic                err_q, err_d;

    logic                coin;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W-1:0] price_btn;
    logic [CREDIT_W-1:0] price_sel;
    logic                res_ok;

    // Coin value, candidate credit and price lookups.
    always_comb begin
        coin      = md | mc;
        coin_val  = (md ? COIN_MD : '0) + (mc ? COIN_MC : '0);
        coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
        price_btn = bc ? P_CAFE : P_TE;
        price_sel = sel_cafe_q ? P_CAFE : P_TE;
        res_ok    = ha & (hc | ~bc);
    end

    // Next-state, credit and registered-output computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        credit_d      = credit_q;
        sel_cafe_d    = sel_cafe_q;
        coin_reject_d = 1'b0;
        change_val_d  = '0;

        unique case (state_q)
            IDLE: begin
                if (coin) begin
                    if (coin_sum <= CR_MAX) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
                if ((bc ^ bt) && (credit_d >= price_btn)) begin
                    if (res_ok) begin
                        sel_cafe_d = bc;
                        cnt_d      = '0;
                        state_d    = HEAT;
                    end else begin
                        state_d      = REFUND;
                        change_val_d = credit_d;
                    end
                end
            end
            HEAT: begin
                coin_reject_d = coin;
                if (!ha) begin
                    state_d      = REFUND;
                    cnt_d        = '0;
                    change_val_d = credit_q;
                end else if (cnt_q == HEAT_LAST) begin
                    state_d = POUR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            POUR: begin
                coin_reject_d = coin;
                if (!ha) begin
                    state_d      = REFUND;
                    cnt_d        = '0;
                    change_val_d = credit_q;
                end else if (cnt_q == POUR_LAST) begin
                    cnt_d    = '0;
                    credit_d = credit_q - price_sel;
                    if (credit_d != '0) begin
                        state_d      = CHANGE;
                        change_val_d = credit_d;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHANGE, REFUND: begin
                coin_reject_d = coin;
                credit_d      = '0;
                cnt_d         = '0;
                state_d       = IDLE;
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
                cnt_d    = '0;
            end
        endcase

        heater_on_d  = (state_d == HEAT);
        pump_on_d    = (state_d == POUR);
        valve_cafe_d = pump_on_d & sel_cafe_d;
        valve_te_d   = pump_on_d & ~sel_cafe_d;
        busy_d       = (state_d != IDLE);
        change_req_d = (state_d == CHANGE) || (state_d == REFUND);
        err_d        = (state_d == REFUND);
    end

    // State, counters, credit and all outputs registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            credit_q      <= '0;
            sel_cafe_q    <= 1'b0;
            heater_on_q   <= 1'b0;
            pump_on_q     <= 1'b0;
            valve_cafe_q  <= 1'b0;
            valve_te_q    <= 1'b0;
            busy_q        <= 1'b0;
            coin_reject_q <= 1'b0;
            change_req_q  <= 1'b0;
            change_val_q  <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            credit_q      <= credit_d;
            sel_cafe_q    <= sel_cafe_d;
            heater_on_q   <= heater_on_d;
            pump_on_q     <= pump_on_d;
            valve_cafe_q  <= valve_cafe_d;
            valve_te_q    <= valve_te_d;
            busy_q        <= busy_d;
            coin_reject_q <= coin_reject_d;
            change_req_q  <= change_req_d;
            change_val_q  <= change_val_d;
            err_q         <= err_d;
        end
    end

    assign heater_on   = heater_on_q;
    assign pump_on     = pump_on_q;
    assign valve_cafe  = valve_cafe_q;
    assign valve_te    = valve_te_q;
    assign busy        = busy_q;
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign change_req  = change_req_q;
    assign change_val  = change_val_q;
    assign err         = err_q;

endmodule

// File: tb/tb_cafe_dispense_sequencer.sv
// Directed bench for cafe_dispense_sequencer with hand-computed
// expected values for each drink scenario.
module tb_cafe_dispense_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       md = 0, mc = 0, bc = 0, bt = 0;
    logic       ha = 1, hc = 1;
    logic       heater_on, pump_on, valve_cafe, valve_te, busy;
    logic [5:0] credit, change_val;
    logic       coin_reject, change_req, err;

    int n_chk  = 0;
    int n_pass = 0;
    int n;
    int saw_chg;
    int bad_valve;

    cafe_dispense_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .md         (md),
        .mc         (mc),
        .bc         (bc),
        .bt         (bt),
        .ha         (ha),
        .hc         (hc),
        .heater_on  (heater_on),
        .pump_on    (pump_on),
        .valve_cafe (valve_cafe),
        .valve_te   (valve_te),
        .busy       (busy),
        .credit     (credit),
        .coin_reject(coin_reject),
        .change_req (change_req),
        .change_val (change_val),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic i_md, input logic i_mc,
                       input logic i_bc, input logic i_bt);
        md = i_md; mc = i_mc; bc = i_bc; bt = i_bt;
        tick();
        md = 0; mc = 0; bc = 0; bt = 0;
    endtask

    task automatic heat_len(output int cnt);
        cnt = 0;
        while (heater_on && cnt < 50) begin
            cnt++;
            tick();
        end
    endtask

    task automatic pour_len(input logic cafe, output int cnt,
                            output int chg, output int badv);
        cnt = 0; chg = 0; badv = 0;
        while (pump_on && cnt < 50) begin
            if (valve_cafe !== cafe || valve_te !== !cafe) badv = 1;
            if (change_req) chg = 1;
            cnt++;
            tick();
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst_heater", 32'(heater_on), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_credit", 32'(credit), 0);
        check("rst_chg", 32'(change_req), 0);
        rst = 0;
        tick();

        // exact-price coffee
        cyc(1, 0, 0, 0);
        check("t1_credit10", 32'(credit), 10);
        cyc(0, 1, 0, 0);
        check("t1_credit15", 32'(credit), 15);
        cyc(0, 0, 1, 0);
        check("t1_heat_lat", 32'(heater_on), 1);
        check("t1_busy", 32'(busy), 1);
        heat_len(n);
        check("t1_heat_len", 32'(n), 8);
        pour_len(1'b1, n, saw_chg, bad_valve);
        check("t1_pour_len", 32'(n), 12);
        check("t1_valve", 32'(bad_valve), 0);
        check("t1_credit0", 32'(credit), 0);
        check("t1_no_chg", 32'(change_req | saw_chg[0]), 0);
        check("t1_idle", 32'(busy), 0);

        // overpay tea
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("t2_credit20", 32'(credit), 20);
        cyc(0, 0, 0, 1);
        heat_len(n);
        check("t2_heat_len", 32'(n), 8);
        pour_len(1'b0, n, saw_chg, bad_valve);
        check("t2_pour_len", 32'(n), 12);
        check("t2_valve", 32'(bad_valve), 0);
        check("t2_chg_req", 32'(change_req), 1);
        check("t2_chg_val", 32'(change_val), 10);
        check("t2_err", 32'(err), 0);
        tick();
        check("t2_chg_pulse", 32'(change_req), 0);
        check("t2_credit0", 32'(credit), 0);
        check("t2_idle", 32'(busy), 0);

        // missing coffee powder
        hc = 0;
        cyc(1, 1, 0, 0);
        check("t3_credit15", 32'(credit), 15);
        cyc(0, 0, 1, 0);
        check("t3_chg_req", 32'(change_req), 1);
        check("t3_err", 32'(err), 1);
        check("t3_chg_val", 32'(change_val), 15);
        check("t3_act", 32'({heater_on, pump_on, valve_cafe, valve_te}), 0);
        tick();
        check("t3_credit0", 32'(credit), 0);
        check("t3_err_pulse", 32'(err), 0);
        check("t3_idle", 32'(busy), 0);
        hc = 1;

        // credit ceiling and coin while busy
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        check("t4_credit40", 32'(credit), 40);
        cyc(1, 0, 0, 0);
        check("t4_reject", 32'(coin_reject), 1);
        check("t4_credit_keep", 32'(credit), 40);
        tick();
        check("t4_reject_pulse", 32'(coin_reject), 0);
        cyc(0, 0, 1, 0);
        heat_len(n);
        check("t4_heat_len", 32'(n), 8);
        cyc(0, 1, 0, 0);
        check("t4_busy_reject", 32'(coin_reject), 1);
        check("t4_busy_credit", 32'(credit), 40);
        pour_len(1'b1, n, saw_chg, bad_valve);
        check("t4_pour_rest", 32'(n), 11);
        check("t4_chg_val", 32'(change_val), 25);
        check("t4_chg_req", 32'(change_req), 1);
        tick();

        // abort at pour cycle 5
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        heat_len(n);
        for (int i = 0; i < 4; i++) tick();
        check("t5_pouring", 32'(pump_on), 1);
        ha = 0;
        tick();
        check("t5_act_off",
              32'({heater_on, pump_on, valve_cafe, valve_te}), 0);
        check("t5_refund", 32'({change_req, err}), 3);
        check("t5_refund_val", 32'(change_val), 20);
        ha = 1;
        tick();
        check("t5_credit0", 32'(credit), 0);

        // selection guards
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 1);
        check("t6_both_btn", 32'(busy), 0);
        check("t6_both_credit", 32'(credit), 10);
        cyc(0, 0, 1, 0);
        check("t6_short_credit", 32'({busy, heater_on, err}), 0);
        cyc(0, 1, 1, 0);
        check("t6_coin_sel_cr", 32'(credit), 15);
        check("t6_coin_sel_ht", 32'(heater_on), 1);

        // async reset mid-heat
        tick();
        #2 rst = 1;
        #1;
        check("t7_rst_heater", 32'(heater_on), 0);
        check("t7_rst_busy", 32'(busy), 0);
        check("t7_rst_credit", 32'(credit), 0);
        #2 rst = 0;
        tick();
        cyc(1, 0, 0, 0);
        check("t7_coin_ok", 32'(credit), 10);
        check("t7_no_reject", 32'(coin_reject), 0);
        check("t7_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
